s_memory_read_port: RTL
=======================

# s_memory_read_port

Read-side controller for the shared 256×8 S memory in the RC4 decrypt design. It accepts level-held read requests from the shuffle (KSA) FSM and the decrypt (PRGA) FSM and arbitrates between them with fixed priority. It drives the memory address, absorbs the synchronous RAM read latency, and returns the data to the granted client with a one-cycle valid pulse. It complements the write-side access mux: the top level routes `mem_read_address` onto the memory address bus whenever `busy` is high.

## Interface
- `ADDR_WIDTH`, 8, S memory address width
- `DATA_WIDTH`, 8, S memory data width
- `READ_LATENCY`, 2, cycles from the address on the bus to valid `mem_q`; legal range 1–3
- `clk`  in  1  system clock
- `reset_n`  in  1  reset, asynchronous assert, active-low
- `shuffle_read_req`  in  1  shuffle FSM read request, held until its valid
- `shuffle_read_address`  in  ADDR_WIDTH  shuffle read address
- `shuffle_read_data`  out  DATA_WIDTH  data returned to shuffle
- `shuffle_read_valid`  out  1  one-cycle pulse; `shuffle_read_data` is valid
- `decrypt_read_req`  in  1  decrypt FSM read request, held until its valid
- `decrypt_read_address`  in  ADDR_WIDTH  decrypt read address
- `decrypt_read_data`  out  DATA_WIDTH  data returned to decrypt
- `decrypt_read_valid`  out  1  one-cycle pulse; `decrypt_read_data` is valid
- `write_active`  in  1  a write-side owner currently holds the memory; blocks new grants
- `mem_read_address`  out  ADDR_WIDTH  registered address to S memory
- `mem_q`  in  DATA_WIDTH  S memory read data
- `busy`  out  1  a read is outstanding (state ≠ IDLE)

## Operation
- States: IDLE, WAIT, RESPOND.
- IDLE:
  - If `write_active` = 0 and any req = 1, grant shuffle if `shuffle_read_req`, else decrypt.
  - On grant, latch the granted address into `mem_read_address`, record the granted client, load the latency counter with READ_LATENCY, and go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter reaches 0, capture `mem_q` into the granted client's data register, pulse that client's valid, and go to RESPOND.
- RESPOND:
  - The valid cycle. Requests are ignored in this state.
  - Go to IDLE next cycle. The client must drop or renew its req during the valid cycle.
- Data registers hold their last value until that client's next response. The other client's outputs are untouched.
- Fixed priority: shuffle beats decrypt when both are high in IDLE. There is no fairness guarantee; the clients are time-exclusive by system design.
- `write_active` rising during WAIT or RESPOND is a system-level protocol violation. The block does not abort the read; the bench flags it with an assertion.
- Reset values: state IDLE, `mem_read_address` 0, both data outputs 0, both valids 0, `busy` 0, counter 0.
- Reset mid-operation drops the pending read. No valid is issued after reset deasserts.

## Timing
- Req sampled high in IDLE at the end of cycle 0.
- `mem_read_address` is valid from cycle 1.
- `mem_q` is sampled at the end of cycle READ_LATENCY.
- Valid and data are visible in cycle READ_LATENCY+1 (RESPOND).
- IDLE again in cycle READ_LATENCY+2.
- Throughput: one read per READ_LATENCY+2 cycles (4 cycles at the default).
- `busy` is high from cycle 1 through cycle READ_LATENCY+1.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- Shared `s_memory_pkg`: state enum (`IDLE`, `WAIT`, `RESPOND`), client enum (`CLIENT_SHUFFLE`, `CLIENT_DECRYPT`), and `S_MEM_ADDR_WIDTH`/`S_MEM_DATA_WIDTH` = 8. The write-side mux imports the same package.
- One sub-module: `s_memory_latency_counter`, a loadable down-counter with a `done` flag, parameterised by READ_LATENCY.

## Test plan
- Reset, then shuffle req with address 0x05, memory preloaded with S[i]=i → `mem_read_address`=0x05 in cycle 1; `shuffle_read_valid` pulses in cycle 3 with data 0x05; `busy` is high in cycles 1–3.
- Both reqs high in the same cycle, shuffle address 0x10, decrypt address 0x20 → shuffle is served first (0x10 at cycle 3); decrypt is served next (0x20 at cycle 7); decrypt data stays 0 until then.
- `write_active`=1 with decrypt req high for 5 cycles → no grant and `busy`=0 throughout; the grant occurs in the first cycle after `write_active` falls.
- Client holds req through RESPOND, then keeps it high for back-to-back reads of 0xFF then 0x00 → exactly one valid per transaction, 4 cycles apart, data 0xFF then 0x00.
- `reset_n` asserted in WAIT → all outputs 0 immediately, no valid after release, state IDLE.
- READ_LATENCY=1 and 3 builds → valid in cycle 2 and cycle 4 respectively; data matches the preloaded S memory.

Source files
------------

// File: rtl/s_memory_pkg.sv
// Shared definitions for the RC4 S memory access blocks (read port and write mux).
package s_memory_pkg;

  localparam int S_MEM_ADDR_WIDTH = 8;
  localparam int S_MEM_DATA_WIDTH = 8;

  // Read-port controller states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RESPOND = 2'd2
  } s_mem_state_e;

  // Clients that may own an outstanding read.
  typedef enum logic {
    CLIENT_SHUFFLE = 1'b0,
    CLIENT_DECRYPT = 1'b1
  } s_mem_client_e;

endpackage

// File: rtl/s_memory_latency_counter.sv
// Loadable down-counter that paces the synchronous RAM read latency.
// done_o marks the last wait cycle: the counter is at 1 and reaches 0 on the
// coming edge, which is the edge on which the RAM output is valid to sample.
module s_memory_latency_counter #(
  parameter int READ_LATENCY = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load_i,
  input  logic en_i,
  output logic done_o
);

  localparam int CNT_W = $clog2(READ_LATENCY + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: load takes precedence, otherwise count down and stop at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = CNT_W'(READ_LATENCY);
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/s_memory_read_port.sv
// Read-side controller for the shared 256x8 RC4 S memory. Arbitrates level-held
// read requests from the shuffle and decrypt FSMs (shuffle wins), drives the
// registered memory address, waits out the RAM latency and returns the data to
// the granted client with a one-cycle valid pulse. Every output is a flop.
// READ_LATENCY is legal in the range 1..3.
module s_memory_read_port
  import s_memory_pkg::*;
#(
  parameter int ADDR_WIDTH   = S_MEM_ADDR_WIDTH,
  parameter int DATA_WIDTH   = S_MEM_DATA_WIDTH,
  parameter int READ_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  shuffle_read_req,
  input  logic [ADDR_WIDTH-1:0] shuffle_read_address,
  output logic [DATA_WIDTH-1:0] shuffle_read_data,
  output logic                  shuffle_read_valid,
  input  logic                  decrypt_read_req,
  input  logic [ADDR_WIDTH-1:0] decrypt_read_address,
  output logic [DATA_WIDTH-1:0] decrypt_read_data,
  output logic                  decrypt_read_valid,
  input  logic                  write_active,
  output logic [ADDR_WIDTH-1:0] mem_read_address,
  input  logic [DATA_WIDTH-1:0] mem_q,
  output logic                  busy
);

  s_mem_state_e    state_q,   state_d;
  s_mem_client_e   client_q,  client_d;
  logic [ADDR_WIDTH-1:0] addr_q,    addr_d;
  logic [DATA_WIDTH-1:0] sh_data_q, sh_data_d;
  logic [DATA_WIDTH-1:0] de_data_q, de_data_d;
  logic            sh_vld_q,  sh_vld_d;
  logic            de_vld_q,  de_vld_d;
  logic            busy_q,    busy_d;

  logic            cnt_load;
  logic            cnt_en;
  logic            cnt_done;

  s_memory_latency_counter #(
    .READ_LATENCY (READ_LATENCY)
  ) u_latency_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .load_i  (cnt_load),
    .en_i    (cnt_en),
    .done_o  (cnt_done)
  );

  // Arbitration, latency wait and response steering.
  always_comb begin
    state_d   = state_q;
    client_d  = client_q;
    addr_d    = addr_q;
    sh_data_d = sh_data_q;
    de_data_d = de_data_q;
    sh_vld_d  = 1'b0;
    de_vld_d  = 1'b0;
    cnt_load  = 1'b0;
    cnt_en    = 1'b0;

    case (state_q)
      IDLE: begin
        // A write owner holds the memory: no new grant until it lets go.
        if (!write_active && (shuffle_read_req || decrypt_read_req)) begin
          cnt_load = 1'b1;
          state_d  = WAIT;
          if (shuffle_read_req) begin
            client_d = CLIENT_SHUFFLE;
            addr_d   = shuffle_read_address;
          end else begin
            client_d = CLIENT_DECRYPT;
            addr_d   = decrypt_read_address;
          end
        end
      end

      WAIT: begin
        cnt_en = 1'b1;
        // Last wait cycle: mem_q is valid now, so capture it on this edge.
        if (cnt_done) begin
          state_d = RESPOND;
          if (client_q == CLIENT_SHUFFLE) begin
            sh_data_d = mem_q;
            sh_vld_d  = 1'b1;
          end else begin
            de_data_d = mem_q;
            de_vld_d  = 1'b1;
          end
        end
      end

      // Valid cycle; requests are deliberately ignored so a held req is not
      // granted twice for one transaction.
      RESPOND: state_d = IDLE;

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // Controller and output registers; reset drops any pending read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      client_q  <= CLIENT_SHUFFLE;
      addr_q    <= '0;
      sh_data_q <= '0;
      de_data_q <= '0;
      sh_vld_q  <= 1'b0;
      de_vld_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      client_q  <= client_d;
      addr_q    <= addr_d;
      sh_data_q <= sh_data_d;
      de_data_q <= de_data_d;
      sh_vld_q  <= sh_vld_d;
      de_vld_q  <= de_vld_d;
      busy_q    <= busy_d;
    end
  end

  assign mem_read_address   = addr_q;
  assign shuffle_read_data  = sh_data_q;
  assign shuffle_read_valid = sh_vld_q;
  assign decrypt_read_data  = de_data_q;
  assign decrypt_read_valid = de_vld_q;
  assign busy               = busy_q;

endmodule
